// File: rtl/uart_echo_responder.sv
// uart_echo_responder
//   Takes bytes from the UART receiver, queues them in a small FIFO and
//   sends them back through the transmitter start/done handshake. It can
//   optionally fold ASCII lowercase to uppercase on the way out. Sticky
//   flags record dropped bytes and aborted (timed-out) transmits.
//
// Ports
//   clk, reset  : system clock, synchronous active-high reset
//   rx_data     : received byte, valid while rx_done=1
//   rx_done     : one-cycle strobe, rx_data valid
//   tx_done     : one-cycle strobe, transmitter finished the stop bit
//   tx_active   : transmitter busy (status only, not used for sequencing)
//   clr_flags   : one-cycle clear of overflow / tx_timeout
//   tx_data     : byte to transmit, held from tx_en until tx_done or abort
//   tx_en       : one-cycle transmit start pulse
//   fifo_count  : FIFO occupancy, 0..2**ADDR_W
//   busy        : FSM is not in IDLE
//   overflow    : sticky, a byte was dropped on a full FIFO
//   tx_timeout  : sticky, a transmit was aborted waiting for tx_done
module uart_echo_responder #(
    parameter int ADDR_W     = 3,
    parameter int CASE_FOLD  = 1,
    parameter int TX_TIMEOUT = 2000000   // must be >= 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic              tx_active,
    input  logic              clr_flags,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    output logic [ADDR_W:0]   fifo_count,
    output logic              busy,
    output logic              overflow,
    output logic              tx_timeout
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t              state, state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count;
    logic [CNT_W-1:0]    tmo_cnt, tmo_inc;
    logic                push, pop, abort;

    // Transmitter busy is informational only; sequencing relies on tx_done.
    logic unused_tx_active;
    assign unused_tx_active = tx_active;

    function automatic logic [7:0] fold(input logic [7:0] b);
        if (CASE_FOLD != 0 && b >= 8'h61 && b <= 8'h7A)
            return b - 8'h20;
        return b;
    endfunction

    assign tmo_inc = tmo_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        abort     = 1'b0;
        tx_en     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_en     = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end else if (tmo_inc == CNT_W'(TX_TIMEOUT - 1)) begin
                    // counter reaches TX_TIMEOUT-1 on this edge: give up
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO still accepts a byte when the head is leaving this cycle.
    assign push = rx_done && ((count != (ADDR_W+1)'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tmo_cnt    <= '0;
            tx_data    <= 8'h00;
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= fold(mem[rd_ptr]);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == START)
                tmo_cnt <= '0;
            else if (state == WAIT_DONE && !tx_done)
                tmo_cnt <= tmo_inc;
            // set beats clear when both happen in the same cycle
            overflow   <= (overflow & ~clr_flags) | (rx_done & ~push);
            tx_timeout <= (tx_timeout & ~clr_flags) | abort;
        end
    end

    assign fifo_count = count;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_echo_responder.sv
module tb_uart_echo_responder;
    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_active;
    logic       clr_flags;

    // instance A: folding on, long timeout (scoreboarded)
    logic [7:0] a_tx_data;
    logic       a_tx_en, a_busy, a_overflow, a_tx_timeout;
    logic [3:0] a_fifo_count;
    // instance B: folding off, short timeout
    logic [7:0] b_tx_data;
    logic       b_tx_en, b_busy, b_overflow, b_tx_timeout;
    logic [3:0] b_fifo_count;

    int ncmp = 0;
    int nerr = 0;
    logic [7:0] exp_q[$];

    uart_echo_responder #(.ADDR_W(3), .CASE_FOLD(1), .TX_TIMEOUT(1000)) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_done(tx_done), .tx_active(tx_active), .clr_flags(clr_flags),
        .tx_data(a_tx_data), .tx_en(a_tx_en), .fifo_count(a_fifo_count),
        .busy(a_busy), .overflow(a_overflow), .tx_timeout(a_tx_timeout)
    );

    uart_echo_responder #(.ADDR_W(3), .CASE_FOLD(0), .TX_TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_done(tx_done), .tx_active(tx_active), .clr_flags(clr_flags),
        .tx_data(b_tx_data), .tx_en(b_tx_en), .fifo_count(b_fifo_count),
        .busy(b_busy), .overflow(b_overflow), .tx_timeout(b_tx_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] model_fold(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A)
            return b - 8'h20;
        return b;
    endfunction

    // scoreboard consumer: every tx_en of instance A must match the next expected byte
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (a_tx_en === 1'b1) begin
                ncmp++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_extra_tx: got tx_en with data %h, required no transmit", a_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a_tx_data !== e) begin
                        nerr++;
                        $display("FAIL sb_tx_data: got %h, required %h", a_tx_data, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit expect_out);
        rx_data = b;
        rx_done = 1'b1;
        if (expect_out)
            exp_q.push_back(model_fold(b));
        tick();
        rx_done = 1'b0;
    endtask

    // answer n transmits of instance A, tx_done dly cycles after it is seen busy
    task automatic serve(input int n, input int dly);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (a_busy !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            if (a_busy !== 1'b1) begin
                ncmp++;
                nerr++;
                $display("FAIL serve_wait: got busy=%b after %0d cycles, required 1", a_busy, w);
                return;
            end
            repeat (dly) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ncmp++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL sb_missing_tx: got %0d bytes not transmitted, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        ncmp++;
        if ({a_tx_data, a_tx_en, a_fifo_count, a_busy, a_overflow, a_tx_timeout} !== 16'h0) begin
            nerr++;
            $display("FAIL reset_a: got data=%h en=%b cnt=%0d busy=%b ovf=%b tmo=%b, required all 0",
                     a_tx_data, a_tx_en, a_fifo_count, a_busy, a_overflow, a_tx_timeout);
        end
        ncmp++;
        if ({b_tx_data, b_tx_en, b_fifo_count, b_busy, b_overflow, b_tx_timeout} !== 16'h0) begin
            nerr++;
            $display("FAIL reset_b: got data=%h en=%b cnt=%0d busy=%b ovf=%b tmo=%b, required all 0",
                     b_tx_data, b_tx_en, b_fifo_count, b_busy, b_overflow, b_tx_timeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_echo();
        do_reset();
        send(8'h61, 1'b1);                       // now cycle N+1
        ncmp++;
        if (a_fifo_count !== 4'd1) begin
            nerr++;
            $display("FAIL echo_count_n1: got %0d, required 1", a_fifo_count);
        end
        tick();                                  // N+2
        ncmp++;
        if (a_tx_en !== 1'b1 || a_tx_data !== 8'h41 || a_fifo_count !== 4'd0) begin
            nerr++;
            $display("FAIL echo_n2: got en=%b data=%h cnt=%0d, required en=1 data=41 cnt=0",
                     a_tx_en, a_tx_data, a_fifo_count);
        end
        ncmp++;
        if (b_tx_en !== 1'b1 || b_tx_data !== 8'h61) begin
            nerr++;
            $display("FAIL nofold_n2: got en=%b data=%h, required en=1 data=61", b_tx_en, b_tx_data);
        end
        repeat (19) tick();
        ncmp++;
        if (a_busy !== 1'b1) begin
            nerr++;
            $display("FAIL echo_busy_wait: got %b, required 1", a_busy);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        ncmp++;
        if (a_busy !== 1'b0) begin
            nerr++;
            $display("FAIL echo_busy_done: got %b, required 0", a_busy);
        end
    endtask

    task automatic test_pass_through();
        logic [7:0] pat [5] = '{8'h5A, 8'h7B, 8'h30, 8'h60, 8'h7A};
        do_reset();
        foreach (pat[i]) send(pat[i], 1'b1);
        serve(5, 3);
        tick();
        ncmp++;
        if (a_busy !== 1'b0 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL pass_drain: got busy=%b pending=%0d, required busy=0 pending=0",
                     a_busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(8'h41, 1'b1);
        send(8'h62, 1'b1);                       // N+2
        ncmp++;
        if (a_tx_en !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_first_en: got %b, required 1", a_tx_en);
        end
        tick();                                  // N+3, tx_done cycle D
        tx_done = 1'b1;
        tick();                                  // D+1
        tx_done = 1'b0;
        ncmp++;
        if (a_tx_en !== 1'b0 || a_busy !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_d1: got en=%b busy=%b, required en=0 busy=0", a_tx_en, a_busy);
        end
        tick();                                  // D+2
        ncmp++;
        if (a_tx_en !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_d2_en: got %b, required 1", a_tx_en);
        end
        serve(1, 1);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 10; k++)
            send(8'(k), k <= 9);
        ncmp++;
        if (a_fifo_count !== 4'd8 || a_overflow !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b, required cnt=8 ovf=1", a_fifo_count, a_overflow);
        end
        // drop and clear in the same cycle: the set wins
        rx_data   = 8'h0B;
        rx_done   = 1'b1;
        clr_flags = 1'b1;
        tick();
        rx_done   = 1'b0;
        clr_flags = 1'b0;
        ncmp++;
        if (a_overflow !== 1'b1 || a_fifo_count !== 4'd8) begin
            nerr++;
            $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d, required ovf=1 cnt=8", a_overflow, a_fifo_count);
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        ncmp++;
        if (a_overflow !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_clear: got %b, required 0", a_overflow);
        end
        serve(9, 2);
        tick();
        ncmp++;
        if (a_fifo_count !== 4'd0 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL ovf_drain: got cnt=%0d pending=%0d, required 0 and 0", a_fifo_count, exp_q.size());
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 0; k < 9; k++)
            send(8'h61 + 8'(k), 1'b1);           // now N+9
        ncmp++;
        if (a_fifo_count !== 4'd8) begin
            nerr++;
            $display("FAIL full_count: got %0d, required 8", a_fifo_count);
        end
        tx_done = 1'b1;
        tick();                                  // IDLE with full FIFO
        tx_done = 1'b0;
        send(8'h6A, 1'b1);                       // pushed while head pops
        ncmp++;
        if (a_fifo_count !== 4'd8 || a_overflow !== 1'b0 || a_tx_en !== 1'b1) begin
            nerr++;
            $display("FAIL full_pop: got cnt=%0d ovf=%b en=%b, required cnt=8 ovf=0 en=1",
                     a_fifo_count, a_overflow, a_tx_en);
        end
        serve(9, 1);
        tick();
        ncmp++;
        if (exp_q.size() != 0 || a_busy !== 1'b0) begin
            nerr++;
            $display("FAIL full_drain: got pending=%0d busy=%b, required 0 and 0", exp_q.size(), a_busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'h55, 1'b1);
        tick();                                  // T: tx_en
        ncmp++;
        if (b_tx_en !== 1'b1) begin
            nerr++;
            $display("FAIL tmo_en: got %b, required 1", b_tx_en);
        end
        repeat (15) tick();                      // T+15
        ncmp++;
        if (b_busy !== 1'b1 || b_tx_timeout !== 1'b0) begin
            nerr++;
            $display("FAIL tmo_t15: got busy=%b tmo=%b, required busy=1 tmo=0", b_busy, b_tx_timeout);
        end
        tick();                                  // T+16
        ncmp++;
        if (b_busy !== 1'b0 || b_tx_timeout !== 1'b1 || b_tx_data !== 8'h55) begin
            nerr++;
            $display("FAIL tmo_t16: got busy=%b tmo=%b data=%h, required busy=0 tmo=1 data=55",
                     b_busy, b_tx_timeout, b_tx_data);
        end
        tx_done = 1'b1;                          // late, must be ignored by B
        tick();
        tx_done = 1'b0;
        ncmp++;
        if (b_busy !== 1'b0 || b_tx_en !== 1'b0 || b_tx_timeout !== 1'b1 || b_fifo_count !== 4'd0) begin
            nerr++;
            $display("FAIL tmo_late_done: got busy=%b en=%b tmo=%b cnt=%0d, required 0 0 1 0",
                     b_busy, b_tx_en, b_tx_timeout, b_fifo_count);
        end
        ncmp++;
        if (a_tx_timeout !== 1'b0 || a_busy !== 1'b0) begin
            nerr++;
            $display("FAIL tmo_long_inst: got tmo=%b busy=%b, required 0 and 0", a_tx_timeout, a_busy);
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        ncmp++;
        if (b_tx_timeout !== 1'b0) begin
            nerr++;
            $display("FAIL tmo_clear: got %b, required 0", b_tx_timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h78, 1'b1);
        send(8'h79, 1'b0);
        send(8'h7A, 1'b0);                       // N+3, WAIT_DONE
        ncmp++;
        if (a_busy !== 1'b1 || a_fifo_count !== 4'd2) begin
            nerr++;
            $display("FAIL rst_mid_pre: got busy=%b cnt=%0d, required busy=1 cnt=2", a_busy, a_fifo_count);
        end
        reset = 1'b1;
        tick();
        ncmp++;
        if (a_fifo_count !== 4'd0 || a_busy !== 1'b0 || a_tx_en !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid: got cnt=%0d busy=%b en=%b, required 0 0 0", a_fifo_count, a_busy, a_tx_en);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tx_done = (k == 2);
            tick();
            ncmp++;
            if (a_tx_en !== 1'b0 || a_busy !== 1'b0 || a_fifo_count !== 4'd0) begin
                nerr++;
                $display("FAIL rst_mid_quiet[%0d]: got en=%b busy=%b cnt=%0d, required 0 0 0",
                         k, a_tx_en, a_busy, a_fifo_count);
            end
        end
        tx_done = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        tx_done   = 1'b0;
        tx_active = 1'b0;
        clr_flags = 1'b0;
        test_reset();
        test_single_echo();
        test_pass_through();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_reset_mid();
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
